// File: rtl/spi_cmd_ctl.sv
// spi_cmd_ctl: parses SPI chip-select transactions into write/read/status commands on a word bus.
// Optional feature macro: SPI_CMD_CTL_BURST_EN (multi-word write/read bursts with auto-increment).
module spi_cmd_ctl #(
   parameter int ADDR_WIDTH = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  spi_cs_n_i,
   input  logic                  spi_byte_vld_i,
   input  logic [7:0]            spi_byte_data_i,
   output logic                  spi_byte_rdy_o,
   output logic [7:0]            spi_byte_data_o,
   output logic [ADDR_WIDTH-1:0] bus_addr_o,
   output logic                  bus_wr_en_o,
   output logic [31:0]           bus_wr_data_o,
   output logic                  bus_rd_en_o,
   input  logic [31:0]           bus_rd_data_i
);

`ifdef SPI_CMD_CTL_BURST_EN
   localparam bit BURST = 1'b1;
`else
   localparam bit BURST = 1'b0;
`endif

   localparam logic [7:0] CMD_WR   = 8'h01;
   localparam logic [7:0] CMD_RD   = 8'h02;
   localparam logic [7:0] CMD_STAT = 8'h03;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR,
      S_WR,
      S_RD,
      S_STAT,
      S_DISC
   } state_e;

   // Every flop of the block lives here so reset and next-state stay in one place.
   typedef struct packed {
      state_e                state;
      logic [1:0]            cnt;       // byte index inside the current 4-byte group
      logic                  is_rd;
      logic [ADDR_WIDTH-1:0] addr;
      logic [23:0]           wr_acc;
      logic [31:0]           cur;
      logic [31:0]           pend;
      logic                  err;
      logic                  rd_vld;    // bus_rd_data_i carries the word requested last cycle
      logic                  rd_pf;     // that word is a prefetch, not the first word
      logic                  rdy;
      logic [7:0]            miso;
      logic [ADDR_WIDTH-1:0] bus_addr;
      logic                  wr_en;
      logic [31:0]           wr_data;
      logic                  rd_en;
   } regs_t;

   regs_t                 r_q, r_d;
   logic [ADDR_WIDTH-1:0] addr_shift;
   logic [ADDR_WIDTH-1:0] addr_inc;

   // NOTE: sequential state uses non-blocking assignments only; the comb block below uses blocking.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_q <= '0;
      end else begin
         r_q <= r_d;
      end
   end

   // NOTE: r_d starts as a full copy of r_q so no path through the case tree can infer a latch.
   always_comb begin
      r_d        = r_q;
      r_d.rdy    = 1'b0;
      r_d.wr_en  = 1'b0;
      r_d.rd_en  = 1'b0;
      r_d.rd_vld = r_q.rd_en;
      addr_shift = {r_q.addr[ADDR_WIDTH-9:0], spi_byte_data_i};
      addr_inc   = r_q.addr + ADDR_WIDTH'(4);

      if (spi_cs_n_i) begin
         // Chip select high drops partial words and any read still in flight.
         r_d.state  = S_IDLE;
         r_d.cnt    = '0;
         r_d.rd_vld = 1'b0;
      end else begin
         if (r_q.rd_vld) begin
            if (r_q.rd_pf) begin
               r_d.pend = bus_rd_data_i;
            end else begin
               r_d.cur  = bus_rd_data_i;
               r_d.rdy  = 1'b1;
               r_d.miso = bus_rd_data_i[31:24];
            end
         end

         if (spi_byte_vld_i) begin
            case (r_q.state)
               S_IDLE: begin
                  r_d.cnt = '0;
                  case (spi_byte_data_i)
                     CMD_WR: begin
                        r_d.state = S_ADDR;
                        r_d.is_rd = 1'b0;
                     end
                     CMD_RD: begin
                        r_d.state = S_ADDR;
                        r_d.is_rd = 1'b1;
                     end
                     CMD_STAT: begin
                        r_d.state = S_STAT;
                        r_d.rdy   = 1'b1;
                        r_d.miso  = {7'b0, r_q.err};
                        r_d.err   = 1'b0;
                     end
                     default: begin
                        r_d.state = S_DISC;
                        r_d.err   = 1'b1;
                     end
                  endcase
               end

               S_ADDR: begin
                  r_d.addr = addr_shift;
                  r_d.cnt  = r_q.cnt + 2'd1;
                  if (r_q.cnt == 2'd3) begin
                     if (r_q.is_rd) begin
                        r_d.state    = S_RD;
                        r_d.rd_en    = 1'b1;
                        r_d.rd_pf    = 1'b0;
                        r_d.bus_addr = addr_shift;
                     end else begin
                        r_d.state = S_WR;
                     end
                  end
               end

               S_WR: begin
                  r_d.wr_acc = {r_q.wr_acc[15:0], spi_byte_data_i};
                  r_d.cnt    = r_q.cnt + 2'd1;
                  if (r_q.cnt == 2'd3) begin
                     r_d.wr_en    = 1'b1;
                     r_d.wr_data  = {r_q.wr_acc, spi_byte_data_i};
                     r_d.bus_addr = r_q.addr;
                     r_d.addr     = addr_inc;
                     if (!BURST) r_d.state = S_DISC;
                  end
               end

               S_RD: begin
                  r_d.cnt = r_q.cnt + 2'd1;
                  case (r_q.cnt)
                     2'd0: begin
                        r_d.rdy  = 1'b1;
                        r_d.miso = r_q.cur[23:16];
                     end
                     2'd1: begin
                        r_d.rdy  = 1'b1;
                        r_d.miso = r_q.cur[15:8];
                        if (BURST) begin
                           r_d.rd_en    = 1'b1;
                           r_d.rd_pf    = 1'b1;
                           r_d.bus_addr = addr_inc;
                        end
                     end
                     2'd2: begin
                        r_d.rdy  = 1'b1;
                        r_d.miso = r_q.cur[7:0];
                     end
                     default: begin
                        if (BURST) begin
                           r_d.cur  = r_q.pend;
                           r_d.rdy  = 1'b1;
                           r_d.miso = r_q.pend[31:24];
                           r_d.addr = addr_inc;
                        end else begin
                           r_d.state = S_DISC;
                        end
                     end
                  endcase
               end

               S_STAT: begin
                  r_d.rdy  = 1'b1;
                  r_d.miso = {7'b0, r_q.err};
                  r_d.err  = 1'b0;
               end

               default: ;
            endcase
         end
      end
   end

   assign spi_byte_rdy_o  = r_q.rdy;
   assign spi_byte_data_o = r_q.miso;
   assign bus_addr_o      = r_q.bus_addr;
   assign bus_wr_en_o     = r_q.wr_en;
   assign bus_wr_data_o   = r_q.wr_data;
   assign bus_rd_en_o     = r_q.rd_en;

endmodule

// File: tb/tb_spi_cmd_ctl.sv
// Self-checking bench for spi_cmd_ctl: transaction vector table plus hand-written timing/reset sequences.
// Expectations follow SPI_CMD_CTL_BURST_EN when the bench is built with it defined.
module tb_spi_cmd_ctl;
   localparam int GAP = 20;
   localparam int NV  = 8;

   logic        clk_i = 1'b0;
   logic        rst_n_i = 1'b0;
   logic        spi_cs_n_i = 1'b1;
   logic        spi_byte_vld_i = 1'b0;
   logic [7:0]  spi_byte_data_i = '0;
   logic        spi_byte_rdy_o;
   logic [7:0]  spi_byte_data_o;
   logic [15:0] bus_addr_o;
   logic        bus_wr_en_o;
   logic [31:0] bus_wr_data_o;
   logic        bus_rd_en_o;
   logic [31:0] bus_rd_data_i = '0;

   spi_cmd_ctl #(.ADDR_WIDTH(16)) dut (
      .clk_i           (clk_i),
      .rst_n_i         (rst_n_i),
      .spi_cs_n_i      (spi_cs_n_i),
      .spi_byte_vld_i  (spi_byte_vld_i),
      .spi_byte_data_i (spi_byte_data_i),
      .spi_byte_rdy_o  (spi_byte_rdy_o),
      .spi_byte_data_o (spi_byte_data_o),
      .bus_addr_o      (bus_addr_o),
      .bus_wr_en_o     (bus_wr_en_o),
      .bus_wr_data_o   (bus_wr_data_o),
      .bus_rd_en_o     (bus_rd_en_o),
      .bus_rd_data_i   (bus_rd_data_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      int          cyc;
      logic [15:0] a;
      logic [31:0] d;
   } ev_t;

   // Byte strings are right-justified: byte 0 of an n-byte field is the most significant one.
   typedef struct packed {
      logic [3:0]   n;
      logic [103:0] mosi;
      logic [1:0]   n_wr;
      logic [15:0]  a0;
      logic [31:0]  d0;
      logic [15:0]  a1;
      logic [31:0]  d1;
      logic [1:0]   n_rd;
      logic [3:0]   n_miso;
      logic [71:0]  miso;
   } vec_t;

   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   n_overlap = 0;
   int   vld_cyc[16];
   ev_t  wr_q[$];
   ev_t  rd_q[$];
   ev_t  rdy_q[$];
   vec_t vecs[NV];
   logic        rd_pend = 1'b0;
   logic [15:0] rd_pend_addr = '0;

   always @(posedge clk_i) cyc <= cyc + 1;

   function automatic logic [31:0] mem_rd(input logic [15:0] a);
      case (a)
         16'h0020: return 32'h1122_3344;
         16'h0024: return 32'h5566_7788;
         default:  return {16'hA5A5, a};
      endcase
   endfunction

   // Bus model and event monitor; read data is driven only during the cycle after the strobe.
   always @(negedge clk_i) begin
      if (rd_pend) bus_rd_data_i = mem_rd(rd_pend_addr);
      else         bus_rd_data_i = 32'hBAD0_0BAD;
      rd_pend = bus_rd_en_o;
      rd_pend_addr = bus_addr_o;
      if (bus_wr_en_o && bus_rd_en_o) n_overlap++;
      if (bus_wr_en_o)    wr_q.push_back('{cyc: cyc, a: bus_addr_o, d: bus_wr_data_o});
      if (bus_rd_en_o)    rd_q.push_back('{cyc: cyc, a: bus_addr_o, d: 32'h0});
      if (spi_byte_rdy_o) rdy_q.push_back('{cyc: cyc, a: 16'h0, d: {24'h0, spi_byte_data_o}});
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] n, input logic [103:0] mosi,
                               input logic [1:0] n_wr, input logic [15:0] a0, input logic [31:0] d0,
                               input logic [15:0] a1, input logic [31:0] d1, input logic [1:0] n_rd,
                               input logic [3:0] n_miso, input logic [71:0] miso);
      vec_t v;
      v.n = n; v.mosi = mosi; v.n_wr = n_wr; v.a0 = a0; v.d0 = d0; v.a1 = a1; v.d1 = d1;
      v.n_rd = n_rd; v.n_miso = n_miso; v.miso = miso;
      return v;
   endfunction

   task automatic send_byte(input logic [7:0] b, output int c);
      @(posedge clk_i); #1;
      spi_byte_data_i = b;
      spi_byte_vld_i  = 1'b1;
      c = cyc;
      @(posedge clk_i); #1;
      spi_byte_vld_i  = 1'b0;
   endtask

   task automatic clear_events();
      wr_q.delete();
      rd_q.delete();
      rdy_q.delete();
   endtask

   task automatic run_vec(input vec_t v);
      clear_events();
      @(posedge clk_i); #1;
      spi_cs_n_i = 1'b0;
      for (int i = 0; i < int'(v.n); i++) begin
         send_byte(v.mosi[8*(int'(v.n)-1-i) +: 8], vld_cyc[i]);
         repeat (GAP) @(posedge clk_i);
      end
      #1 spi_cs_n_i = 1'b1;
      repeat (5) @(posedge clk_i);
   endtask

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "simulation time limit");
   end

   initial begin : main
      vec_t        cv;
      logic [71:0] m;
      int          dummy;
      bit          seen;

      vecs[0] = mk(4'd9,  104'h01_00000010_DEADBEEF, 2'd1, 16'h0010, 32'hDEADBEEF, 16'h0, 32'h0, 2'd0, 4'd0, 72'h0);
`ifdef SPI_CMD_CTL_BURST_EN
      vecs[1] = mk(4'd13, 104'h02_00000020_FFFFFFFF_FFFFFFFF, 2'd0, 16'h0, 32'h0, 16'h0, 32'h0, 2'd3,
                   4'd9, 72'h11223344_55667788_A5);
      vecs[2] = mk(4'd13, 104'h01_1234FFFC_01020304_05060708, 2'd2, 16'hFFFC, 32'h01020304,
                   16'h0000, 32'h05060708, 2'd0, 4'd0, 72'h0);
`else
      vecs[1] = mk(4'd13, 104'h02_00000020_FFFFFFFF_FFFFFFFF, 2'd0, 16'h0, 32'h0, 16'h0, 32'h0, 2'd1,
                   4'd4, 72'h11223344);
      vecs[2] = mk(4'd13, 104'h01_1234FFFC_01020304_05060708, 2'd1, 16'hFFFC, 32'h01020304,
                   16'h0, 32'h0, 2'd0, 4'd0, 72'h0);
`endif
      vecs[3] = mk(4'd3,  104'h7E0000, 2'd0, 16'h0, 32'h0, 16'h0, 32'h0, 2'd0, 4'd0, 72'h0);
      vecs[4] = mk(4'd3,  104'h03AABB, 2'd0, 16'h0, 32'h0, 16'h0, 32'h0, 2'd0, 4'd3, 72'h010000);
      vecs[5] = mk(4'd7,  104'h01_00000040_1122, 2'd0, 16'h0, 32'h0, 16'h0, 32'h0, 2'd0, 4'd0, 72'h0);
      vecs[6] = mk(4'd9,  104'h01_00000044_CAFEBABE, 2'd1, 16'h0044, 32'hCAFEBABE, 16'h0, 32'h0, 2'd0, 4'd0, 72'h0);
      vecs[7] = mk(4'd1,  104'h03, 2'd0, 16'h0, 32'h0, 16'h0, 32'h0, 2'd0, 4'd1, 72'h00);

      repeat (3) @(posedge clk_i);
      #1;
      check("reset outputs", {spi_byte_rdy_o, spi_byte_data_o, bus_addr_o, bus_wr_en_o, bus_wr_data_o, bus_rd_en_o}, 64'h0);
      rst_n_i = 1'b1;

      for (int v = 0; v < NV; v++) begin
         cv = vecs[v];
         m  = cv.miso;
         run_vec(cv);
         check($sformatf("v%0d wr count", v), wr_q.size(), cv.n_wr);
         for (int i = 0; i < wr_q.size() && i < 2; i++) begin
            check($sformatf("v%0d wr%0d addr", v, i), wr_q[i].a, (i == 0) ? cv.a0 : cv.a1);
            check($sformatf("v%0d wr%0d data", v, i), wr_q[i].d, (i == 0) ? cv.d0 : cv.d1);
         end
         check($sformatf("v%0d rd count", v), rd_q.size(), cv.n_rd);
         check($sformatf("v%0d reload count", v), rdy_q.size(), cv.n_miso);
         for (int i = 0; i < rdy_q.size() && i < int'(cv.n_miso); i++)
            check($sformatf("v%0d reload%0d", v, i), rdy_q[i].d, {24'h0, m[8*(int'(cv.n_miso)-1-i) +: 8]});
      end

      // Write strobe latency.
      run_vec(vecs[0]);
      check("wr latency", (wr_q.size() > 0) ? 64'(wr_q[0].cyc - vld_cyc[8]) : 64'hFFFF, 64'd1);

      // Read start latency, first MISO reload latency and prefetch timing.
      run_vec(vecs[1]);
      check("rd addr", (rd_q.size() > 0) ? 64'(rd_q[0].a) : 64'hFFFF, 64'h20);
      check("rd latency", (rd_q.size() > 0) ? 64'(rd_q[0].cyc - vld_cyc[4]) : 64'hFFFF, 64'd1);
      check("first reload latency", (rdy_q.size() > 0) ? 64'(rdy_q[0].cyc - vld_cyc[4]) : 64'hFFFF, 64'd3);
      check("next reload latency", (rdy_q.size() > 1) ? 64'(rdy_q[1].cyc - vld_cyc[5]) : 64'hFFFF, 64'd1);
`ifdef SPI_CMD_CTL_BURST_EN
      check("prefetch addr", (rd_q.size() > 1) ? 64'(rd_q[1].a) : 64'hFFFF, 64'h24);
      check("prefetch latency", (rd_q.size() > 1) ? 64'(rd_q[1].cyc - vld_cyc[6]) : 64'hFFFF, 64'd1);
`endif

      // Status byte latency on the command byte itself.
      run_vec(vecs[7]);
      check("status latency", (rdy_q.size() > 0) ? 64'(rdy_q[0].cyc - vld_cyc[0]) : 64'hFFFF, 64'd1);

      // Reset between the read strobe and the first MISO reload.
      clear_events();
      @(posedge clk_i); #1;
      spi_cs_n_i = 1'b0;
      send_byte(8'h02, dummy);
      for (int i = 0; i < 4; i++) begin
         repeat (GAP) @(posedge clk_i);
         send_byte((i == 3) ? 8'h20 : 8'h00, dummy);
      end
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk_i);
         seen = bus_rd_en_o;
      end
      check("rst seq rd strobe seen", seen, 1'b1);
      @(posedge clk_i); #1;
      rst_n_i = 1'b0;
      #1;
      check("rst seq outputs", {spi_byte_rdy_o, spi_byte_data_o, bus_addr_o, bus_wr_en_o, bus_wr_data_o, bus_rd_en_o}, 64'h0);
      repeat (4) @(posedge clk_i);
      #1 rst_n_i = 1'b1;
      repeat (4) @(posedge clk_i);
      check("rst seq no reload", rdy_q.size(), 64'd0);
      // Chip select stays low: the next byte must be taken as a fresh command.
      run_vec(mk(4'd9, 104'h01_00000050_01020304, 2'd1, 16'h0050, 32'h01020304, 16'h0, 32'h0, 2'd0, 4'd0, 72'h0));
      check("rst seq idle wr count", wr_q.size(), 64'd1);
      check("rst seq idle wr addr", (wr_q.size() > 0) ? 64'(wr_q[0].a) : 64'hFFFF, 64'h50);
      check("rst seq idle wr data", (wr_q.size() > 0) ? 64'(wr_q[0].d) : 64'hFFFF, 64'h01020304);

      check("wr/rd strobe overlap", n_overlap, 64'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
